// File: rtl/clock_gen_pkg.sv
// rtl/clock_gen_pkg.sv - shared types for the clock generator
package clock_gen_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

endpackage

// File: rtl/clock_gen_half_period_counter.sv
// rtl/clock_gen_half_period_counter.sv - half-period counter with clear and terminal count
module half_period_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // half_i is never 0, so half_i-1 cannot underflow
  assign tc_o = (cnt_q == half_i - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_gen.sv
// rtl/clock_gen.sv - divided 50% duty clock with rise/fall strobes in the reference domain
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int HALF_PERIOD = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  logic [CNT_W-1:0] half_q, half_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             tc;
  edge_e            edge_kind;

  half_period_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .clr_i (div_load),
    .half_i(half_q),
    .tc_o  (tc)
  );

  // A divisor load wins over counting and restarts the half-period without touching the level
  always_comb begin
    half_d    = half_q;
    clk_d     = clk_q;
    edge_kind = EDGE_NONE;
    if (div_load) begin
      half_d = (div_value == '0) ? CNT_W'(1) : div_value;
    end else if (en && tc) begin
      clk_d     = ~clk_q;
      edge_kind = clk_q ? EDGE_FALL : EDGE_RISE;
    end
    rise_d = (edge_kind == EDGE_RISE);
    fall_d = (edge_kind == EDGE_FALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= CNT_W'(HALF_PERIOD);
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      half_q <= half_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign clk_out    = clk_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_clock_gen.sv
// tb/tb_clock_gen.sv - scoreboard bench for clock_gen against a countdown reference model
module tb_clock_gen;

  localparam int CNT_W = 8;
  localparam int HP    = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             clk_out;
  logic             rise_pulse;
  logic             fall_pulse;

  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_half, m_rem;
  logic m_lvl;
  int   cyc, first_rise, n_rise, n_fall;

  always #5 clk = ~clk;

  clock_gen #(
    .CNT_W      (CNT_W),
    .HALF_PERIOD(HP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_load  (div_load),
    .div_value (div_value),
    .clk_out   (clk_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_half = HP;
    m_rem  = HP;
    m_lvl  = 1'b0;
  endtask

  // Reference: edges remaining until the next toggle, reloaded with the half-period
  task automatic step(input logic e, input logic l, input int v);
    exp_t x;
    x = '0;
    en        = e;
    div_load  = l;
    div_value = CNT_W'(v);
    if (l) begin
      m_half = (v == 0) ? 1 : v;
      m_rem  = m_half;
    end else if (e) begin
      m_rem--;
      if (m_rem == 0) begin
        m_lvl  = ~m_lvl;
        x.rise = m_lvl;
        x.fall = ~m_lvl;
        m_rem  = m_half;
      end
    end
    x.lvl = m_lvl;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cyc++;
      check("clk_out", clk_out, mon_e.lvl);
      check("rise_pulse", rise_pulse, mon_e.rise);
      check("fall_pulse", fall_pulse, mon_e.fall);
      check("strobe_mutex", rise_pulse & fall_pulse, 0);
      check("cnt_lt_half", dut.u_cnt.cnt_q < dut.half_q, 1);
      if (rise_pulse) begin
        n_rise++;
        if (first_rise < 0) first_rise = cyc;
      end
      if (fall_pulse) n_fall++;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_value = '0;
    model_reset();
    @(posedge clk); #1;
    check("reset_clk_out", clk_out, 0);
    check("reset_rise", rise_pulse, 0);
    check("reset_fall", fall_pulse, 0);
    @(negedge clk);
    rst = 1'b0;

    // default divider over 20 full periods
    cyc = 0; first_rise = -1; n_rise = 0; n_fall = 0;
    repeat (480) step(1'b1, 1'b0, 0);
    check("first_rise_edge", first_rise, 12);
    check("rise_count_480", n_rise, 20);
    check("fall_count_480", n_fall, 20);

    // enable dropped for 5 cycles at cnt=7 delays the toggle by 5
    do_reset();
    repeat (7) step(1'b1, 1'b0, 0);
    repeat (5) step(1'b0, 1'b0, 0);
    repeat (4) step(1'b1, 1'b0, 0);
    check("hold_before_toggle", clk_out, 0);
    step(1'b1, 1'b0, 0);
    check("toggle_after_resume", clk_out, 1);

    // load 3 while high: level kept, falls 3 edges later
    do_reset();
    repeat (14) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 3);
    check("load_keeps_level", clk_out, 1);
    repeat (2) step(1'b1, 1'b0, 0);
    check("load_still_high", clk_out, 1);
    step(1'b1, 1'b0, 0);
    check("load_falls_at_3", clk_out, 0);
    repeat (12) step(1'b1, 1'b0, 0);

    // divisor 0 behaves as 1
    step(1'b1, 1'b1, 0);
    n_rise = 0; n_fall = 0;
    repeat (10) step(1'b1, 1'b0, 0);
    check("div0_rises", n_rise, 5);
    check("div0_falls", n_fall, 5);

    // async reset mid-period while high, right after a rise strobe
    do_reset();
    step(1'b1, 1'b1, 3);
    repeat (3) step(1'b1, 1'b0, 0);
    check("pre_reset_high", clk_out, 1);
    check("pre_reset_rise", rise_pulse, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    check("async_clk_out", clk_out, 0);
    check("async_rise", rise_pulse, 0);
    check("async_fall", fall_pulse, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; first_rise = -1;
    repeat (24) step(1'b1, 1'b0, 0);
    check("post_reset_first_rise", first_rise, 12);

    // randomized enable / load traffic
    do_reset();
    repeat (3000) step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, $urandom_range(0, 5));

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
